// File: rtl/uart_led_pwm_ctrl.sv
// UART byte decoder driving NUM_CH PWM LED channels; optional blink gating under LED_BLINK_EN.
// States: IDLE | decode command bytes;  WAIT_VAL | expect value byte after a header, with timeout.
module uart_led_pwm_ctrl #(
  parameter int NUM_CH      = 3,
  parameter int PWM_BITS    = 8,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int BLINK_HALF  = 6000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_byte,
  input  logic              rx_done,
  output logic [NUM_CH-1:0] led,
  output logic              cmd_err,
  output logic              busy
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]       TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;
  localparam logic [7:0]          DIG_LAST  = 8'(8'h30 + NUM_CH - 1);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("NUM_CH must be in 1..8");
  end
  if (PWM_BITS < 2 || PWM_BITS > 8) begin : g_bad_pwm_bits
    $error("PWM_BITS must be in 2..8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end
  if (BLINK_HALF < 2) begin : g_bad_blink
    $error("BLINK_HALF must be at least 2");
  end

  typedef enum logic {IDLE, WAIT_VAL} state_e;

  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] duty_q [NUM_CH];
  logic [PWM_BITS-1:0] duty_d [NUM_CH];
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [CW-1:0]       pend_q, pend_d;
  logic                err_q, err_d;
  logic [NUM_CH-1:0]   led_q, led_d;

  logic                let_vld;
  logic                let_on;
  logic [1:0]          let_ch;
  logic                is_digit;

`ifdef LED_BLINK_EN
  localparam int BW = $clog2(BLINK_HALF);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  logic              mask_tgt_q, mask_tgt_d;
  logic [NUM_CH-1:0] blink_mask_q, blink_mask_d;
  logic [BW-1:0]     blink_cnt_q;
  logic              blink_phase_q;
`endif

  assign is_digit = (rx_byte >= 8'h30) && (rx_byte <= DIG_LAST);

  always_comb begin
    let_vld = 1'b0;
    let_on  = 1'b0;
    let_ch  = 2'd0;
    case (rx_byte)
      8'h52: begin let_vld = 1'b1; let_on = 1'b1; let_ch = 2'd0; end
      8'h47: begin let_vld = 1'b1; let_on = 1'b1; let_ch = 2'd1; end
      8'h42: begin let_vld = 1'b1; let_on = 1'b1; let_ch = 2'd2; end
      8'h72: begin let_vld = 1'b1; let_on = 1'b0; let_ch = 2'd0; end
      8'h67: begin let_vld = 1'b1; let_on = 1'b0; let_ch = 2'd1; end
      8'h62: begin let_vld = 1'b1; let_on = 1'b0; let_ch = 2'd2; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tmo_d   = tmo_q;
    pend_d  = pend_q;
    err_d   = 1'b0;
`ifdef LED_BLINK_EN
    mask_tgt_d   = mask_tgt_q;
    blink_mask_d = blink_mask_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rx_done) begin
          if (let_vld && (32'(let_ch) < NUM_CH)) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (32'(let_ch) == k) duty_d[k] = let_on ? DUTY_FULL : '0;
            end
          end else if (rx_byte == 8'h21) begin
            for (int k = 0; k < NUM_CH; k++) duty_d[k] = '0;
`ifdef LED_BLINK_EN
            blink_mask_d = '0;
`endif
          end else if (is_digit) begin
            pend_d  = rx_byte[CW-1:0];
            tmo_d   = '0;
            state_d = WAIT_VAL;
`ifdef LED_BLINK_EN
            mask_tgt_d = 1'b0;
          end else if (rx_byte == 8'h4B) begin
            mask_tgt_d = 1'b1;
            tmo_d      = '0;
            state_d    = WAIT_VAL;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_VAL: begin
        // A byte on the timeout cycle wins over the timeout.
        if (rx_done) begin
          state_d = IDLE;
`ifdef LED_BLINK_EN
          if (mask_tgt_q) begin
            blink_mask_d = rx_byte[NUM_CH-1:0];
          end else begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (32'(pend_q) == k) duty_d[k] = rx_byte[PWM_BITS-1:0];
            end
          end
`else
          for (int k = 0; k < NUM_CH; k++) begin
            if (32'(pend_q) == k) duty_d[k] = rx_byte[PWM_BITS-1:0];
          end
`endif
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    led_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
`ifdef LED_BLINK_EN
      led_d[k] = ((duty_q[k] == DUTY_FULL) || (pwm_cnt_q < duty_q[k]))
                 && (blink_phase_q || !blink_mask_q[k]);
`else
      led_d[k] = (duty_q[k] == DUTY_FULL) || (pwm_cnt_q < duty_q[k]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      for (int k = 0; k < NUM_CH; k++) duty_q[k] <= '0;
      pwm_cnt_q <= '0;
      tmo_q     <= '0;
      pend_q    <= '0;
      err_q     <= 1'b0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      tmo_q     <= tmo_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      led_q     <= led_d;
    end
  end

`ifdef LED_BLINK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_tgt_q    <= 1'b0;
      blink_mask_q  <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      mask_tgt_q   <= mask_tgt_d;
      blink_mask_q <= blink_mask_d;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end
`endif

  assign led     = led_q;
  assign cmd_err = err_q;
  assign busy    = (state_q == WAIT_VAL);

endmodule

// File: tb/tb_uart_led_pwm_ctrl.sv
// Directed bench for uart_led_pwm_ctrl with NUM_CH=3, PWM_BITS=8, TIMEOUT_CYC=16, BLINK_HALF=32.
module tb_uart_led_pwm_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_done = 1'b0;
  logic [2:0] led;
  logic       cmd_err;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  uart_led_pwm_ctrl #(
    .NUM_CH(3), .PWM_BITS(8), .TIMEOUT_CYC(16), .BLINK_HALF(32)
  ) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_done(rx_done),
    .led(led), .cmd_err(cmd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobes one byte; returns just after the edge that samples it.
  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      hi += int'(led[ch]);
    end
  endtask

  task automatic count_any(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (led != 3'b000) hi++;
    end
  endtask

  initial begin
    int hi;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_led", 32'(led), 0);
    chk("reset_err", 32'(cmd_err), 0);
    chk("reset_busy", 32'(busy), 0);

    // 'R': led[0] full on from the 2nd edge
    send(8'h52);
    chk("R_lat_edge1", 32'(led), 0);
    tick();
    chk("R_lat_edge2", 32'(led), 3'b001);
    count_high(0, 512, hi);
    chk("R_ch0_512", 32'(hi), 512);
    count_any(1, hi);
    chk("R_ch21_off", 32'(led[2:1]), 0);

    // '1', 0x40: 64/256 on channel 1
    send(8'h31);
    chk("set1_busy", 32'(busy), 1);
    tick();
    tick();
    chk("set1_busy_hold", 32'(busy), 1);
    send(8'h40);
    chk("set1_busy_drop", 32'(busy), 0);
    chk("set1_no_err", 32'(cmd_err), 0);
    count_high(1, 256, hi);
    chk("duty40_ch1", 32'(hi), 64);
    send(8'h67);
    tick();
    count_high(1, 256, hi);
    chk("g_ch1_off", 32'(hi), 0);

    // Set duty[2]=0x80, then let a header time out
    send(8'h32);
    tick();
    send(8'h80);
    send(8'h32);
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_busy_before", 32'(busy), 1);
    chk("tmo_err_before", 32'(cmd_err), 0);
    tick();
    chk("tmo_busy_after", 32'(busy), 0);
    chk("tmo_err_pulse", 32'(cmd_err), 1);
    tick();
    chk("tmo_err_single", 32'(cmd_err), 0);
    count_high(2, 256, hi);
    chk("tmo_duty_kept", 32'(hi), 128);

    // Value byte on the exact timeout cycle is accepted
    send(8'h32);
    for (int i = 0; i < 15; i++) tick();
    send(8'h20);
    chk("edge_busy", 32'(busy), 0);
    chk("edge_no_err", 32'(cmd_err), 0);
    tick();
    chk("edge_no_err2", 32'(cmd_err), 0);
    count_high(2, 256, hi);
    chk("edge_duty20", 32'(hi), 32);

    // '0' then 'r' as data, then '!'
    send(8'h30);
    tick();
    send(8'h72);
    chk("r_as_data_err", 32'(cmd_err), 0);
    count_high(0, 256, hi);
    chk("duty72_ch0", 32'(hi), 114);
    send(8'h21);
    count_any(256, hi);
    chk("alloff", 32'(hi), 0);

    // Unknown bytes
    send(8'h5A);
    chk("Z_err", 32'(cmd_err), 1);
    chk("Z_busy", 32'(busy), 0);
    tick();
    chk("Z_err_single", 32'(cmd_err), 0);
    send(8'h35);
    chk("5_err", 32'(cmd_err), 1);
    chk("5_busy", 32'(busy), 0);
    tick();
    chk("5_err_single", 32'(cmd_err), 0);
`ifndef LED_BLINK_EN
    send(8'h4B);
    chk("K_unknown_err", 32'(cmd_err), 1);
    chk("K_unknown_busy", 32'(busy), 0);
    tick();
`endif
    count_any(256, hi);
    chk("unknown_no_change", 32'(hi), 0);

    // Reset in WAIT_VAL discards the pending command
    send(8'h52);
    tick();
    send(8'h31);
    chk("rst_pre_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_led", 32'(led), 0);
    send(8'h80);
    chk("post_rst_err", 32'(cmd_err), 1);
    chk("post_rst_busy", 32'(busy), 0);
    count_any(256, hi);
    chk("post_rst_dark", 32'(hi), 0);

`ifdef LED_BLINK_EN
    begin
      int last = -1;
      int ntog = 0;
      logic prev;
      send(8'h52);
      tick();
      send(8'h4B);
      chk("K_busy", 32'(busy), 1);
      tick();
      send(8'h01);
      chk("K_no_err", 32'(cmd_err), 0);
      tick();
      prev = led[0];
      for (int i = 0; i < 200; i++) begin
        tick();
        if (led[0] != prev) begin
          if (last >= 0) chk("blink_half", 32'(i - last), 32);
          last = i;
          ntog++;
          prev = led[0];
        end
      end
      chk("blink_toggles", 32'(ntog >= 5), 1);
      send(8'h21);
      count_any(100, hi);
      chk("blink_alloff", 32'(hi), 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
